// File: rtl/i2c_controller.sv
// i2c_controller: single-master I2C engine issuing one sub-addressed register
// write or read per command on open-drain SCL/SDA.
// Optional build macro I2C_CTRL_CLK_STRETCH_EN: while SCL is released but still
// sensed low (target stretching), the quarter-period counter holds, with no timeout.
module i2c_controller #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       wr_rdn,
  input  logic [6:0] dev_addr,
  input  logic [7:0] sub_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oe,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_TX_BYTE, ST_RX_ACK, ST_RESTART,
    ST_RX_BYTE, ST_TX_NACK, ST_STOP, ST_DONE
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [1:0]      q_r;       // quarter within the current bit slot
  logic [2:0]      bit_r;     // bit index within the current byte
  logic [1:0]      byte_r;    // 0 addr+W, 1 sub_addr, 2 wdata, 3 addr+R
  logic [7:0]      shift_r;   // outgoing byte, MSB first
  logic [7:0]      rx_r;      // incoming byte, MSB first
  logic            wr_r;
  logic [6:0]      addr_r;
  logic [7:0]      sub_r;
  logic [7:0]      wd_r;
  logic            nack_r;
  logic            scl_oe_r;
  logic            sda_oe_r;
  logic [7:0]      rdata_r;
  logic            busy_r;
  logic            done_r;
  logic            ack_err_r;
  logic            hold_s;
  logic            tick_s;

`ifdef I2C_CTRL_CLK_STRETCH_EN
  // Hold the quarter counter while a released SCL is still held low by the target
  always_comb begin
    if (busy_r && !scl_oe_r && !scl_i) hold_s = 1'b1;
    else hold_s = 1'b0;
  end
`else
  logic unused_s;
  // Timing is purely counter-based; SCL sense is not needed
  assign hold_s   = 1'b0;
  assign unused_s = scl_i;
`endif

  // Quarter-period tick: one pulse every CLK_DIV busy cycles
  always_comb begin
    if (busy_r && !hold_s && (cnt_r == CNT_MAX)) tick_s = 1'b1;
    else tick_s = 1'b0;
  end

  // Quarter-period counter, runs only while a command is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!busy_r) begin
      cnt_r <= '0;
    end else if (hold_s) begin
      cnt_r <= cnt_r;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Command sequencer: walks START, bytes, ACKs, RESTART and STOP one quarter per tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      q_r       <= 2'd0;
      bit_r     <= 3'd0;
      byte_r    <= 2'd0;
      shift_r   <= 8'h00;
      rx_r      <= 8'h00;
      wr_r      <= 1'b0;
      addr_r    <= 7'h00;
      sub_r     <= 8'h00;
      wd_r      <= 8'h00;
      nack_r    <= 1'b0;
      scl_oe_r  <= 1'b0;
      sda_oe_r  <= 1'b0;
      rdata_r   <= 8'h00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            wr_r      <= wr_rdn;
            addr_r    <= dev_addr;
            sub_r     <= sub_addr;
            wd_r      <= wdata;
            ack_err_r <= 1'b0;
            busy_r    <= 1'b1;
            q_r       <= 2'd0;
            state_r   <= ST_START;
          end
        end
        // Completion cycle: a start strobe seen here is deliberately dropped
        ST_DONE: state_r <= ST_IDLE;
        default: begin
          if (tick_s) begin
            q_r <= q_r + 2'd1;
            case (state_r)
              ST_START: begin
                case (q_r)
                  2'd0: begin scl_oe_r <= 1'b0; sda_oe_r <= 1'b0; end
                  2'd1: sda_oe_r <= 1'b0;
                  2'd2: sda_oe_r <= 1'b1;
                  default: begin
                    scl_oe_r <= 1'b1;
                    shift_r  <= {addr_r, 1'b0};
                    bit_r    <= 3'd0;
                    byte_r   <= 2'd0;
                    state_r  <= ST_TX_BYTE;
                  end
                endcase
              end
              ST_TX_BYTE: begin
                case (q_r)
                  2'd0: sda_oe_r <= ~shift_r[7];
                  2'd1: scl_oe_r <= 1'b0;
                  2'd2: scl_oe_r <= 1'b0;
                  default: begin
                    scl_oe_r <= 1'b1;
                    shift_r  <= {shift_r[6:0], 1'b0};
                    bit_r    <= bit_r + 3'd1;
                    if (bit_r == 3'd7) state_r <= ST_RX_ACK;
                    else state_r <= ST_TX_BYTE;
                  end
                endcase
              end
              ST_RX_ACK: begin
                case (q_r)
                  2'd0: sda_oe_r <= 1'b0;
                  2'd1: scl_oe_r <= 1'b0;
                  2'd2: nack_r   <= sda_i;
                  default: begin
                    scl_oe_r <= 1'b1;
                    bit_r    <= 3'd0;
                    if (nack_r) begin
                      ack_err_r <= 1'b1;
                      state_r   <= ST_STOP;
                    end else begin
                      case (byte_r)
                        2'd0: begin
                          shift_r <= sub_r;
                          byte_r  <= 2'd1;
                          state_r <= ST_TX_BYTE;
                        end
                        2'd1: begin
                          if (wr_r) begin
                            shift_r <= wd_r;
                            byte_r  <= 2'd2;
                            state_r <= ST_TX_BYTE;
                          end else begin
                            state_r <= ST_RESTART;
                          end
                        end
                        2'd2: state_r <= ST_STOP;
                        default: state_r <= ST_RX_BYTE;
                      endcase
                    end
                  end
                endcase
              end
              ST_RESTART: begin
                case (q_r)
                  2'd0: sda_oe_r <= 1'b0;
                  2'd1: scl_oe_r <= 1'b0;
                  2'd2: sda_oe_r <= 1'b1;
                  default: begin
                    scl_oe_r <= 1'b1;
                    shift_r  <= {addr_r, 1'b1};
                    byte_r   <= 2'd3;
                    bit_r    <= 3'd0;
                    state_r  <= ST_TX_BYTE;
                  end
                endcase
              end
              ST_RX_BYTE: begin
                case (q_r)
                  2'd0: sda_oe_r <= 1'b0;
                  2'd1: scl_oe_r <= 1'b0;
                  2'd2: rx_r     <= {rx_r[6:0], sda_i};
                  default: begin
                    scl_oe_r <= 1'b1;
                    bit_r    <= bit_r + 3'd1;
                    if (bit_r == 3'd7) state_r <= ST_TX_NACK;
                    else state_r <= ST_RX_BYTE;
                  end
                endcase
              end
              ST_TX_NACK: begin
                case (q_r)
                  2'd0: sda_oe_r <= 1'b0;
                  2'd1: scl_oe_r <= 1'b0;
                  2'd2: sda_oe_r <= 1'b0;
                  default: begin
                    scl_oe_r <= 1'b1;
                    rdata_r  <= rx_r;
                    state_r  <= ST_STOP;
                  end
                endcase
              end
              ST_STOP: begin
                case (q_r)
                  2'd0: sda_oe_r <= 1'b1;
                  2'd1: scl_oe_r <= 1'b0;
                  2'd2: sda_oe_r <= 1'b0;
                  default: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_DONE;
                  end
                endcase
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign rdata   = rdata_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign ack_err = ack_err_r;
  assign scl_oe  = scl_oe_r;
  assign sda_oe  = sda_oe_r;
  assign scl_o   = 1'b0;
  assign sda_o   = 1'b0;

endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: randomized register writes/reads against a behavioural
// I2C target at 0x70, with a scoreboard checking rdata, ack_err, latency and
// the START/STOP/NACK pattern observed on the bus.
`timescale 1ns/1ps
module tb_i2c_controller;
  localparam int CLK_DIV = 4;
  localparam logic [6:0] TGT = 7'h70;

  typedef struct {
    logic [7:0] rdata;
    logic       ack_err;
    int         lat;
    int         t0;
    int         starts0;
    int         stops0;
    bit         rd_ok;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       wr_rdn = 1'b0;
  logic [6:0] dev_addr = 7'h00;
  logic [7:0] sub_addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy, done, ack_err;
  logic       scl_i, scl_o, scl_oe, sda_i, sda_o, sda_oe;
  logic       stretch = 1'b0;
  logic       tgt_oe = 1'b0;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_start = 0;
  int         n_stop = 0;
  logic       m_nack = 1'b0;
  logic [7:0] shadow [0:255];
  logic [7:0] exp_rdata = 8'h00;
  exp_t       sb_q[$];
  exp_t       mon_e;

  // Open-drain wired-AND of the bus
  assign scl_i = ~scl_oe & ~stretch;
  assign sda_i = ~sda_oe & ~tgt_oe;

  i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_rdn(wr_rdn),
    .dev_addr(dev_addr), .sub_addr(sub_addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
    .scl_i(scl_i), .scl_o(scl_o), .scl_oe(scl_oe),
    .sda_i(sda_i), .sda_o(sda_o), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural I2C target: register file at TGT, pointer set by first data byte
  initial begin : target
    logic [7:0] tregs [0:255];
    logic scl_l, sda_l, p_scl, p_sda, rw;
    logic [7:0] sh, tdata, ptr;
    int mode, bc, bidx;  // mode: 0 idle, 1 receive, 2 ack out, 3 send, 4 master ack
    for (int i = 0; i < 256; i++) tregs[i] = 8'h00;
    p_scl = 1'b1; p_sda = 1'b1; rw = 1'b0; sh = 8'h00; tdata = 8'h00; ptr = 8'h00;
    mode = 0; bc = 0; bidx = 0;
    forever begin
      @(negedge clk);
      scl_l = scl_i;
      sda_l = sda_i;
      if (p_scl && scl_l && p_sda && !sda_l) begin
        n_start++; mode = 1; bc = 0; bidx = 0; tgt_oe = 1'b0; m_nack = 1'b0;
      end else if (p_scl && scl_l && !p_sda && sda_l) begin
        n_stop++; mode = 0; tgt_oe = 1'b0;
      end else if (!p_scl && scl_l) begin
        if (mode == 1) begin sh = {sh[6:0], sda_l}; bc++; end
        else if (mode == 4) m_nack = sda_l;
      end else if (p_scl && !scl_l) begin
        case (mode)
          1: if (bc == 8) begin
               bc = 0;
               if (bidx == 0) begin
                 rw = sh[0];
                 if (sh[7:1] == TGT) begin mode = 2; tgt_oe = 1'b1; end
                 else mode = 0;
               end else begin
                 if (bidx == 1) ptr = sh;
                 else begin tregs[ptr] = sh; ptr = ptr + 8'd1; end
                 mode = 2; tgt_oe = 1'b1;
               end
               bidx++;
             end
          2: begin
               tgt_oe = 1'b0;
               if (rw) begin tdata = tregs[ptr]; tgt_oe = ~tdata[7]; bc = 1; mode = 3; end
               else mode = 1;
             end
          3: if (bc == 8) begin tgt_oe = 1'b0; mode = 4; end
             else begin tgt_oe = ~tdata[7 - bc]; bc++; end
          4: mode = 0;
          default: mode = 0;
        endcase
      end
      p_scl = scl_l;
      p_sda = sda_l;
    end
  end

  // Scoreboard monitor: every done pulse is matched with the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("latency", cyc - mon_e.t0 + 1, mon_e.lat);
        chk("ack_err", {31'd0, ack_err}, {31'd0, mon_e.ack_err});
        chk("rdata", {24'd0, rdata}, {24'd0, mon_e.rdata});
        chk("busy_with_done", {31'd0, busy}, 32'd0);
        chk("bus_starts", n_start - mon_e.starts0, mon_e.rd_ok ? 2 : 1);
        chk("bus_stops", n_stop - mon_e.stops0, 1);
        if (mon_e.rd_ok) chk("master_nack", {31'd0, m_nack}, 32'd1);
      end
    end
  end

  // Issue one command; expectation comes from the protocol rules and a shadow register file
  task automatic run_txn(input logic wr, input logic [6:0] a, input logic [7:0] s,
                         input logic [7:0] d, input bit poke, input int extra);
    exp_t e;
    bit ok;
    int ticks;
    ok = (a == TGT);
    ticks = !ok ? 44 : (wr ? 116 : 156);
    if (ok && !wr) exp_rdata = shadow[s];
    if (ok && wr) shadow[s] = d;
    e.rdata   = exp_rdata;
    e.ack_err = !ok;
    e.lat     = ticks * CLK_DIV + 1 + extra;
    e.rd_ok   = ok && !wr;
    e.starts0 = n_start;
    e.stops0  = n_stop;
    @(negedge clk);
    start = 1'b1; wr_rdn = wr; dev_addr = a; sub_addr = s; wdata = d;
    @(posedge clk); #1;
    start = 1'b0;
    e.t0 = cyc;
    sb_q.push_back(e);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    if (poke) begin
      repeat (100) @(negedge clk);
      start = 1'b1; wr_rdn = ~wr; dev_addr = a ^ 7'h11; sub_addr = ~s; wdata = ~d;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 4000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("busy_fall", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    logic [6:0] a;
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
    chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("scl_o_const", {31'd0, scl_o}, 32'd0);
    chk("sda_o_const", {31'd0, sda_o}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Directed: write, read back, absent target, start while busy
    run_txn(1'b1, TGT, 8'h05, 8'hA5, 1'b0, 0);
    run_txn(1'b0, TGT, 8'h05, 8'h00, 1'b0, 0);
    run_txn(1'b1, 7'h22, 8'h05, 8'h3C, 1'b0, 0);
    run_txn(1'b0, 7'h22, 8'h06, 8'h00, 1'b0, 0);
    run_txn(1'b1, TGT, 8'h06, 8'h5B, 1'b1, 0);
    run_txn(1'b0, TGT, 8'h06, 8'h00, 1'b1, 0);

    // Reset in the middle of the address byte
    @(negedge clk);
    start = 1'b1; wr_rdn = 1'b1; dev_addr = TGT; sub_addr = 8'h40; wdata = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (98) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rdata", {24'd0, rdata}, 32'd0);
    exp_rdata = 8'h00;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_txn(1'b1, TGT, 8'h41, 8'hC3, 1'b0, 0);
    run_txn(1'b0, TGT, 8'h41, 8'h00, 1'b0, 0);
    run_txn(1'b0, TGT, 8'h40, 8'h00, 1'b0, 0);

    // Randomized mix of writes, reads, absent targets and ignored strobes
    for (int n = 0; n < 20; n++) begin
      a = TGT;
      if ($urandom_range(0, 3) == 0) begin
        a = 7'($urandom_range(0, 127));
        if (a == TGT) a = 7'h22;
      end
      run_txn(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 0);
    end

`ifdef I2C_CTRL_CLK_STRETCH_EN
    // Target stretches SCL for 50 cycles at the sub-address ACK
    fork
      run_txn(1'b1, TGT, 8'h33, 8'h5A, 1'b0, 50);
      begin
        int nrel;
        logic p;
        nrel = 0;
        p = 1'b0;
        for (int g = 0; g < 5000 && nrel < 18; g++) begin
          @(negedge clk);
          if (p && !scl_oe) nrel++;
          p = scl_oe;
        end
        stretch = 1'b1;
        repeat (50) @(negedge clk);
        stretch = 1'b0;
      end
    join
    run_txn(1'b0, TGT, 8'h33, 8'h00, 1'b0, 0);
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
